// File: rtl/uart_frame_loader.sv
// Syncs on a start-of-frame byte from the UART receiver and writes IMG_H*IMG_W pixels
// into the frame buffer in row-major order, then locks the buffer until the pipeline releases it.
module uart_frame_loader #(
  parameter int          IMG_W       = 28,
  parameter int          IMG_H       = 28,
  parameter int          ADDR_W      = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              pipe_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_loaded,
  output logic              loading,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ARM,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              frame_loaded_q, frame_loaded_d;
  logic              overrun_q, overrun_d;
  logic              timeout_err_q, timeout_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pix_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      frame_loaded_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      frame_loaded_q <= frame_loaded_d;
      overrun_q      <= overrun_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pix_cnt_d      = pix_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    frame_loaded_d = 1'b0;
    overrun_d      = 1'b0;
    timeout_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d   = S_LOAD;
          pix_cnt_d = '0;
          tmo_cnt_d = '0;
        end
      end
      S_LOAD: begin
        // A byte arriving on the expiry cycle still counts as a pixel.
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_cnt_q;
          wr_data_d = rx_data;
          tmo_cnt_d = '0;
          if (pix_cnt_q == LAST_PIX) begin
            state_d   = S_DONE;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
          end
        end else if (TIMEOUT_CYC != 0) begin
          if ((tmo_cnt_q + TMO_W'(1)) == TMO_LIMIT) begin
            state_d       = S_IDLE;
            timeout_err_d = 1'b1;
            tmo_cnt_d     = '0;
            pix_cnt_d     = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end
      S_DONE: begin
        overrun_d      = rx_valid;
        frame_loaded_d = 1'b1;
        state_d        = S_ARM;
      end
      S_ARM: begin
        overrun_d = rx_valid;
        if (pipe_busy) state_d = S_HOLD;
      end
      S_HOLD: begin
        overrun_d = rx_valid;
        if (!pipe_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_loaded = frame_loaded_q;
  assign loading      = (state_q == S_LOAD);
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: table of opening vectors, directed frame scenarios and a
// randomized run, all checked every cycle against a frame-level reference model.
module tb_uart_frame_loader;

  localparam int         NPIX = 784;
  localparam int         TMO  = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       pipe_busy = 1'b0;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_loaded, loading, overrun, timeout_err;

  uart_frame_loader #(
    .IMG_W(28), .IMG_H(28), .ADDR_W(10), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .pipe_busy(pipe_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_loaded(frame_loaded), .loading(loading), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stepn = 0;

  // Reference model: frame-level view (collecting pixels / buffer locked / waiting for sync)
  bit         m_collect, m_locked, m_busy_seen;
  int         m_pix, m_idle, m_lock_age;
  bit         e_we, e_fl, e_load, e_ov, e_to;
  int         e_addr;
  logic [7:0] e_data;

  int n_we, n_fl, n_ov, n_to, last_v, fl_at, to_at, first_addr;

  typedef struct {
    bit v; logic [7:0] d; bit b;
    bit we; int addr; logic [7:0] data; bit load; bit ov;
  } vec_t;
  vec_t tbl[9];

  task automatic model_reset();
    m_collect = 0; m_locked = 0; m_busy_seen = 0;
    m_pix = 0; m_idle = 0; m_lock_age = 0;
    e_we = 0; e_fl = 0; e_load = 0; e_ov = 0; e_to = 0; e_addr = 0; e_data = 8'h00;
  endtask

  // Predicts the outputs seen one cycle after these inputs are presented.
  task automatic model_step(input bit v, input logic [7:0] d, input bit b);
    e_we = 0; e_fl = 0; e_ov = 0; e_to = 0;
    if (m_locked) begin
      e_ov = v;
      if (m_lock_age == 0) e_fl = 1;
      else if (!m_busy_seen) m_busy_seen = b;
      else if (!b) m_locked = 0;
      m_lock_age++;
    end else if (m_collect) begin
      if (v) begin
        e_we = 1; e_addr = m_pix; e_data = d;
        m_pix++; m_idle = 0;
        if (m_pix == NPIX) begin
          m_collect = 0; m_locked = 1; m_lock_age = 0; m_busy_seen = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin m_collect = 0; e_to = 1; end
      end
    end else if (v && d == SYNC) begin
      m_collect = 1; m_pix = 0; m_idle = 0;
    end
    e_load = m_collect;
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_obs();
    n_we = 0; n_fl = 0; n_ov = 0; n_to = 0; first_addr = -1;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit b);
    bit ok;
    rx_valid = v; rx_data = d; pipe_busy = b;
    if (v) last_v = stepn;
    model_step(v, d, b);
    @(posedge clk); #1;
    stepn++;
    if (wr_en) begin
      if (n_we == 0) first_addr = int'(wr_addr);
      n_we++;
    end
    if (frame_loaded) begin n_fl++; fl_at = stepn; end
    if (overrun) n_ov++;
    if (timeout_err) begin n_to++; to_at = stepn; end
    ok = (wr_en === e_we) && (!e_we || (int'(wr_addr) === e_addr && wr_data === e_data)) &&
         (frame_loaded === e_fl) && (loading === e_load) && (overrun === e_ov) &&
         (timeout_err === e_to);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cycle %0d: got we=%0b addr=%0d data=%h fl=%0b load=%0b ov=%0b to=%0b expected we=%0b addr=%0d data=%h fl=%0b load=%0b ov=%0b to=%0b",
               stepn, wr_en, wr_addr, wr_data, frame_loaded, loading, overrun, timeout_err,
               e_we, e_addr, e_data, e_fl, e_load, e_ov, e_to);
    end
  endtask

  task automatic do_reset();
    reset = 1; rx_valid = 0; pipe_busy = 0;
    @(posedge clk); #1;
    stepn++;
    reset = 0;
    model_reset();
    check_eq("reset_outputs",
             int'({wr_en, wr_addr, wr_data, frame_loaded, loading, overrun, timeout_err}), 0);
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) step(0, 8'h00, b);
  endtask

  // kind 0: byte = index mod 256; kind 1: first 10 pixels are SYNC, rest random
  task automatic send_frame(input int kind, input int npix);
    logic [7:0] px;
    step(1, SYNC, 0);
    for (int i = 0; i < npix; i++) begin
      if (kind == 0) px = 8'(i % 256);
      else px = (i < 10) ? SYNC : 8'($urandom_range(0, 255));
      step(1, px, 0);
    end
  endtask

  task automatic release_buf();
    idle(3, 1);
    idle(3, 0);
  endtask

  initial begin
    logic [7:0] rd;
    bit         rb;
    bit         ok;

    tbl[0] = '{1, 8'h00, 0, 0, 0, 8'h00, 0, 0};
    tbl[1] = '{1, 8'hFF, 0, 0, 0, 8'h00, 0, 0};
    tbl[2] = '{1, 8'h13, 0, 0, 0, 8'h00, 0, 0};
    tbl[3] = '{0, 8'h00, 0, 0, 0, 8'h00, 0, 0};
    tbl[4] = '{1, 8'hA5, 0, 0, 0, 8'h00, 1, 0};
    tbl[5] = '{1, 8'h3C, 0, 1, 0, 8'h3C, 1, 0};
    tbl[6] = '{1, 8'hA5, 0, 1, 1, 8'hA5, 1, 0};
    tbl[7] = '{0, 8'h00, 1, 0, 0, 8'h00, 1, 0};
    tbl[8] = '{1, 8'h7E, 0, 1, 2, 8'h7E, 1, 0};

    model_reset();
    clr_obs();
    do_reset();

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].b);
      ok = (wr_en === tbl[i].we) &&
           (!tbl[i].we || (int'(wr_addr) === tbl[i].addr && wr_data === tbl[i].data)) &&
           (loading === tbl[i].load) && (overrun === tbl[i].ov);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL table[%0d]: got we=%0b addr=%0d data=%h load=%0b ov=%0b expected we=%0b addr=%0d data=%h load=%0b ov=%0b",
                 i, wr_en, wr_addr, wr_data, loading, overrun,
                 tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].load, tbl[i].ov);
      end
    end
    do_reset();

    // Nominal frame
    clr_obs();
    send_frame(0, NPIX);
    idle(3, 0);
    check_eq("nom_writes", n_we, NPIX);
    check_eq("nom_first_addr", first_addr, 0);
    check_eq("nom_frame_loaded", n_fl, 1);
    check_eq("nom_latency", fl_at - last_v, 2);
    check_eq("nom_overrun", n_ov, 0);
    release_buf();

    // Garbage before sync
    clr_obs();
    step(1, 8'h00, 0); step(1, 8'hFF, 0); step(1, 8'h13, 0);
    check_eq("garbage_no_write", n_we, 0);
    send_frame(0, NPIX);
    idle(3, 0);
    check_eq("garbage_writes", n_we, NPIX);
    check_eq("garbage_overrun", n_ov, 0);
    check_eq("garbage_frame_loaded", n_fl, 1);
    release_buf();

    // Sync value as pixel data
    clr_obs();
    send_frame(1, NPIX);
    idle(3, 0);
    check_eq("syncpix_writes", n_we, NPIX);
    check_eq("syncpix_frame_loaded", n_fl, 1);
    release_buf();

    // Lockout while the pipeline holds the buffer
    clr_obs();
    send_frame(0, NPIX);
    idle(2, 0);
    check_eq("lock_frame_loaded", n_fl, 1);
    clr_obs();
    for (int i = 0; i < 500; i++) begin
      if (i == 100 || i == 400) step(1, 8'h55, 1);
      else if (i == 250) step(1, SYNC, 1);
      else step(0, 8'h00, 1);
    end
    check_eq("lock_overruns", n_ov, 3);
    check_eq("lock_writes", n_we, 0);
    idle(1, 0);
    check_eq("lock_release_loading", int'(loading), 0);
    clr_obs();
    step(1, SYNC, 0);
    step(1, 8'h42, 0);
    check_eq("lock_after_first_addr", first_addr, 0);
    check_eq("lock_after_writes", n_we, 1);
    do_reset();

    // Inter-byte timeout
    clr_obs();
    send_frame(0, 10);
    idle(120, 0);
    check_eq("tmo_count", n_to, 1);
    check_eq("tmo_latency", to_at - last_v, TMO + 1);
    check_eq("tmo_writes", n_we, 10);
    check_eq("tmo_loading", int'(loading), 0);
    clr_obs();
    step(1, SYNC, 0);
    step(1, 8'h11, 0);
    check_eq("tmo_restart_addr", first_addr, 0);
    idle(TMO - 1, 0);
    step(1, 8'h22, 0);
    idle(TMO - 1, 0);
    check_eq("tmo_byte_wins", n_to, 0);
    check_eq("tmo_byte_wins_writes", n_we, 2);
    idle(5, 0);
    check_eq("tmo_second_expiry", n_to, 1);

    // Reset in the middle of a frame
    clr_obs();
    send_frame(0, 400);
    do_reset();
    idle(3, 0);
    check_eq("midreset_no_frame_loaded", n_fl, 0);
    clr_obs();
    send_frame(0, NPIX);
    idle(3, 0);
    check_eq("midreset_first_addr", first_addr, 0);
    check_eq("midreset_writes", n_we, NPIX);
    check_eq("midreset_frame_loaded", n_fl, 1);
    release_buf();

    // Randomized traffic against the model
    rb = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 49) == 0) rb = ~rb;
      if ($urandom_range(0, 1499) == 0) begin
        idle($urandom_range(TMO - 10, TMO + 10), rb);
      end else begin
        rd = ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom_range(0, 255));
        step($urandom_range(0, 3) != 0, rd, rb);
      end
    end
    idle(5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
